// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 frames recovered from an oversampled serial line.
// Each good byte is presented with a one-cycle done strobe; a low stop bit gives frame_err.
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       frame_err,
  output logic [1:0] state_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, rx_q, prev_q;
  logic          rx;

  assign rx = rx_q;

  // prev_q advances on ticks only, so a falling edge is never lost between sparse ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_q    <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= in;
      rx_q    <= sync1_q;
      if (en) prev_q <= rx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (prev_q && !rx) begin
            tick_d  = '0;
            state_d = START;
          end
        end
        START: begin
          if (tick_q == TICK_MID) begin
            if (!rx) begin
              tick_d  = '0;
              bit_d   = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            shift_d = {rx, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            state_d = IDLE;
            if (rx) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign frame_err = ferr_q;
  assign state_o   = state_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage. It is the direct downstream partner of the UART transmitter: it consumes the transmitter's serial `out` line and recovers 8-bit frames (1 start, 8 data LSB-first, 1 stop, no parity). Bit timing comes from an oversampling tick enable `en`. Each recovered byte is presented with a one-cycle `done` strobe; bad stop bits raise a one-cycle `frame_err` strobe.

## Interface
- `OVERSAMPLE`, 16: `en` ticks per bit period. Must be even and ≥ 4.
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: oversample tick. The FSM and counters advance only on `clk` edges where `en`=1. All other state freezes, except the input synchronizer, which runs every `clk`.
- `in` input 1: serial line. Idles high. Asynchronous to `clk`.
- `data_out` output 8: last correctly framed byte. Held until the next good frame.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `done` output 1: one-`clk` pulse when a good frame completes.
- `frame_err` output 1: one-`clk` pulse when the stop bit samples low.

## Operation
- Input synchronizer: 2-flop chain on `in`, reset to 1. A third register holds the previous synchronized value for falling-edge detection. All logic uses the synchronized value `rx`.
- Tick counter: $clog2(OVERSAMPLE) bits. Bit counter: 3 bits. Shift register: 8 bits.
- States:
  - IDLE: wait for a falling edge on `rx` (previous 1, current 0), gated by `en`. On the edge, clear the tick counter and go to START.
  - START: count OVERSAMPLE/2 − 1 further ticks to reach mid-bit. At mid-bit, if `rx`=0, clear the tick and bit counters and go to DATA. If `rx`=1, it was a glitch: return to IDLE with no strobe.
  - DATA: every OVERSAMPLE ticks, sample `rx` into the shift register LSB-first (shift right, `rx` enters bit 7). After bit counter = 7, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample `rx`.
    - If 1: load `data_out` from the shift register, pulse `done`.
    - If 0: pulse `frame_err`, leave `data_out` unchanged.
    - In both cases, return to IDLE.
- Falling-edge detection only: a line held low (break, or a low stop bit) does not retrigger. A new frame needs a 1→0 transition.
- `done` and `frame_err` are mutually exclusive and never high for more than one `clk`.

## Timing
- Reset values: `data_out`=8'h00, `busy`=0, `done`=0, `frame_err`=0, FSM=IDLE, counters=0, synchronizer=1.
- Sync latency: `rx` follows `in` 2 `clk` later.
- With `en` held high, ticks = clocks:
  - Falling edge seen on `rx` at cycle T.
  - Start mid-sample at T+OVERSAMPLE/2.
  - Data bit k sampled at T+OVERSAMPLE/2+(k+1)·OVERSAMPLE.
  - Stop sampled at T+OVERSAMPLE/2+9·OVERSAMPLE.
  - `done`/`frame_err` and the new `data_out` appear on the `clk` edge of the stop sample (registered, visible the following cycle).
- `busy` rises one `clk` after the edge is detected. It falls in the same edge that pulses `done`/`frame_err`.
- `en`=0 mid-frame: all FSM state holds. Sampling resumes, bit-aligned, when `en` returns.
- Back-to-back frames: a start edge immediately after a good stop bit is detected in IDLE on the next `en` tick. There are no dead cycles beyond one tick.
- `rst` mid-frame: immediate return to the reset values. A partial byte is discarded, with no strobe.

## Test plan
- Idle line high for 100 `clk`, `en`=1: `busy`, `done` and `frame_err` stay 0, and `data_out`=8'h00.
- Drive a frame 8'hAA at 16 clk/bit, `en`=1 continuously: a single `done` pulse about 154 `clk` after the start edge, `data_out`=8'hAA, `frame_err`=0, `busy` high throughout the frame.
- Connect to the UART transmitter (shared `clk`/`en` scheme). Send 8'hAA, then 8'h55 back-to-back: two `done` pulses with `data_out` 8'hAA, then 8'h55.
- Frame 8'h3C with stop bit forced 0: one `frame_err` pulse, no `done`, `data_out` keeps its previous value. The line held low afterwards must not start a new frame until it goes high and falls again.
- Low glitch of 4 `clk` on an idle line: the FSM enters START, then returns to IDLE at mid-bit with no strobe.
- Assert `rst` during data bit 4 of 8'hF0: outputs return to reset values immediately. A following clean 8'h0F frame is received correctly.
